instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have parameter NUM_WORDS, default 128, meaning the number of words written before the load completes (1..2^ADDR_W).
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, the asynchronous active-high reset.
REQ-006 Port load_en, input, 1, load-session enable; high SHALL request a load, low SHALL abort or idle.
REQ-007 Port byte_valid, input, 1, byte_data is valid this cycle.
REQ-008 Port byte_data, input, 8, incoming program byte.
REQ-009 Port byte_ready, output, 1, the block can accept a byte this cycle.
REQ-010 Port mem_we, output, 1, instruction-memory write strobe, one cycle per word.
REQ-011 Port mem_addr, output, ADDR_W, instruction-memory word address.
REQ-012 Port mem_wdata, output, 32, assembled instruction word.
REQ-013 Port cpu_hold, output, 1, holds the CPU in reset while a load is in progress.
REQ-014 Port load_done, output, 1, all NUM_WORDS words have been written.

Function
REQ-015 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both high.
REQ-016 The FSM SHALL have exactly four states: IDLE, COLLECT, WRITE and DONE.
REQ-017 From IDLE, load_en high SHALL move the FSM to COLLECT and clear the address and byte counters.
REQ-018 byte_ready SHALL be high only in COLLECT; it SHALL be low in IDLE, WRITE and DONE.
REQ-019 Bytes SHALL be assembled little-endian: the first accepted byte goes to bits 7:0 and the fourth to bits 31:24.
REQ-020 Acceptance of the fourth byte in cycle N SHALL move the FSM to WRITE, with mem_we high during cycle N+1 and mem_wdata/mem_addr stable during that cycle.
REQ-021 After WRITE, mem_addr SHALL increment by 1 and the FSM SHALL return to COLLECT, unless the word just written was number NUM_WORDS, in which case the FSM SHALL go to DONE.
REQ-022 mem_addr SHALL be modulo 2^ADDR_W; with NUM_WORDS = 2^ADDR_W, the last write SHALL be at address all-ones and no wrap SHALL be observable.
REQ-023 In DONE, load_done SHALL be high and cpu_hold low; load_en low SHALL return the FSM to IDLE with load_done cleared.
REQ-024 cpu_hold SHALL be high in COLLECT and WRITE, and low in IDLE and DONE.
REQ-025 load_en falling in COLLECT SHALL discard any partial word, force the next state to IDLE, and produce no write.
REQ-026 load_en falling in WRITE SHALL still complete that write, then go to IDLE.
REQ-027 byte_valid in any state other than COLLECT SHALL be ignored and SHALL NOT change the byte counter.
REQ-028 Apart from mem_we and the registers listed above, outputs SHALL hold their values.

Reset
REQ-029 rst high SHALL asynchronously force state IDLE, byte counter 0, mem_addr 0, mem_wdata 0, mem_we 0, byte_ready 0, cpu_hold 0 and load_done 0.
REQ-030 rst asserted mid-load SHALL abandon the load immediately with no further mem_we, and a new load SHALL restart at address 0.

Structure
REQ-031 A shared package SHALL hold the FSM state enumeration, the WORD_BYTES = 4 constant and the 32-bit instruction word width.
REQ-032 One sub-module, byte_packer, SHALL contain the 2-bit byte counter and the 32-bit shift/assembly register, with clear and accept inputs and a word_full output.
REQ-033 The FSM, address counter and outputs SHALL reside in instr_loader.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Stream 8 bytes 0x13,0x05,0x10,0x00,0xB3,0x85,0xA5,0x00 with byte_valid held high -> writes 0x00100513@0 and 0x00A585B3@1, each mem_we exactly one cycle.
REQ-036 Insert random byte_valid gaps with NUM_WORDS = 2 -> identical writes, load_done rises the cycle after the second write, and cpu_hold falls with it.
REQ-037 Drop load_en after 2 bytes of word 3 -> no write to address 3, FSM returns to IDLE; a new load writes its first word at address 0.
REQ-038 Assert rst during the WRITE cycle of word 5 -> all outputs 0 within the same cycle; the subsequent load restarts at address 0.
REQ-039 Run with ADDR_W = 2 and NUM_WORDS = 4, loading 16 bytes -> addresses 0,1,2,3 written, then DONE with no fifth write.
REQ-040 Drive byte_valid high in IDLE and DONE -> byte_ready stays 0, no mem_we, and the byte counter is unchanged.

Source files
------------

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared types and constants for the instruction loader:
//               loader FSM states, bytes per word and instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    // Bytes that make up one instruction word
    localparam int WORD_BYTES = 4;

    // Instruction word width in bits
    localparam int INSTR_W = 32;

    // Width of the byte-within-word counter
    localparam int BCNT_W = $clog2(WORD_BYTES);

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles incoming bytes little-endian into one instruction
//               word. word presents the word as it will look once the byte
//               on byte_in is accepted, so the completed word is available
//               in the same cycle that word_full flags the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [BCNT_W-1:0]  r_byte_cnt;
    logic [INSTR_W-1:0] r_word;
    logic [INSTR_W-1:0] w_word;

    // Merge the incoming byte into the lane selected by the byte counter
    always_comb begin
        w_word = r_word;
        w_word[{r_byte_cnt, 3'b000} +: 8] = byte_in;
    end

    assign word      = w_word;
    assign word_full = accept && (r_byte_cnt == BCNT_W'(WORD_BYTES - 1));

    // Byte counter and assembly register; the counter wraps after the last lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (accept) begin
            r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            r_word     <= w_word;
        end
    end

endmodule : byte_packer
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Receives a program as a byte stream, packs it into 32-bit
//               words and writes NUM_WORDS consecutive words to instruction
//               memory while holding the CPU in reset. All outputs are
//               registered from the next-state decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int NUM_WORDS = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               load_done
);

    // Address of the final word of the load
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_WORDS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_byte_ready;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INSTR_W-1:0] r_mem_wdata;
    logic               r_cpu_hold;
    logic               r_load_done;

    logic               w_accept;
    logic               w_clear;
    logic               w_addr_inc;
    logic               w_word_full;
    logic [INSTR_W-1:0] w_word;

    // byte_ready is registered high exactly while in COLLECT, so it also
    // gates acceptance to that state
    assign w_accept   = byte_valid && r_byte_ready;
    assign w_clear    = (r_state == IDLE) && load_en;
    assign w_addr_inc = (r_state == WRITE) && load_en && (r_mem_addr != c_last_addr);

    byte_packer u_byte_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .accept    (w_accept),
        .byte_in   (byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a dropped load_en always wins and returns to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_en) begin
                    w_next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (!load_en) begin
                    w_next_state = IDLE;
                end else if (w_word_full) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                if (!load_en) begin
                    w_next_state = IDLE;
                end else if (r_mem_addr == c_last_addr) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = COLLECT;
                end
            end
            DONE: begin
                if (!load_en) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_byte_ready <= (w_next_state == COLLECT);
            r_mem_we     <= (w_next_state == WRITE);
            r_cpu_hold   <= (w_next_state == COLLECT) || (w_next_state == WRITE);
            r_load_done  <= (w_next_state == DONE);
            if (w_next_state == WRITE) begin
                r_mem_wdata <= w_word;
            end
        end
    end

    // Word address: cleared at load start, advanced after each non-final write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
        end else if (w_clear) begin
            r_mem_addr <= '0;
        end else if (w_addr_inc) begin
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Directed bench for instr_loader. Three instances:
//               [0] default sizing, [1] ADDR_W=2/NUM_WORDS=4,
//               [2] NUM_WORDS=2 fed with random byte_valid gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    logic        clk;
    logic        rst;
    logic        load_en    [3];
    logic        byte_valid [3];
    logic [7:0]  byte_data  [3];
    logic        byte_ready [3];
    logic        mem_we     [3];
    logic [31:0] mem_wdata  [3];
    logic        cpu_hold   [3];
    logic        load_done  [3];
    logic [6:0]  addr_a;
    logic [1:0]  addr_b;
    logic [6:0]  addr_c;

    int errors = 0;
    int checks = 0;

    // Logged writes: {addr(7), data(32)}
    logic [38:0] q0[$];
    logic [38:0] q1[$];
    logic [38:0] q2[$];

    logic [7:0]  s1   [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h85, 8'hA5, 8'h00};
    logic [31:0] wb   [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

    instr_loader u_a (
        .clk(clk), .rst(rst), .load_en(load_en[0]), .byte_valid(byte_valid[0]),
        .byte_data(byte_data[0]), .byte_ready(byte_ready[0]), .mem_we(mem_we[0]),
        .mem_addr(addr_a), .mem_wdata(mem_wdata[0]), .cpu_hold(cpu_hold[0]),
        .load_done(load_done[0])
    );

    instr_loader #(.ADDR_W(2), .NUM_WORDS(4)) u_b (
        .clk(clk), .rst(rst), .load_en(load_en[1]), .byte_valid(byte_valid[1]),
        .byte_data(byte_data[1]), .byte_ready(byte_ready[1]), .mem_we(mem_we[1]),
        .mem_addr(addr_b), .mem_wdata(mem_wdata[1]), .cpu_hold(cpu_hold[1]),
        .load_done(load_done[1])
    );

    instr_loader #(.ADDR_W(7), .NUM_WORDS(2)) u_c (
        .clk(clk), .rst(rst), .load_en(load_en[2]), .byte_valid(byte_valid[2]),
        .byte_data(byte_data[2]), .byte_ready(byte_ready[2]), .mem_we(mem_we[2]),
        .mem_addr(addr_c), .mem_wdata(mem_wdata[2]), .cpu_hold(cpu_hold[2]),
        .load_done(load_done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we[0]) q0.push_back({addr_a, mem_wdata[0]});
        if (mem_we[1]) q1.push_back({5'd0, addr_b, mem_wdata[1]});
        if (mem_we[2]) q2.push_back({addr_c, mem_wdata[2]});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted
    task automatic send_byte(input int idx, input logic [7:0] b, input int gap);
        int n;
        byte_valid[idx] = 1'b0;
        repeat (gap) step();
        byte_valid[idx] = 1'b1;
        byte_data[idx]  = b;
        n = 0;
        while (!byte_ready[idx] && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 64'(byte_ready[idx]), 64'd1);
        step();
        byte_valid[idx] = 1'b0;
    endtask

    initial begin
        int qn;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_en[i] = 1'b0; byte_valid[i] = 1'b0; byte_data[i] = 8'h00;
        end
        repeat (3) step();

        // Reset state
        chk("rst_ready", 64'(byte_ready[0]), 64'd0);
        chk("rst_we",    64'(mem_we[0]),     64'd0);
        chk("rst_addr",  64'(addr_a),        64'd0);
        chk("rst_wdata", 64'(mem_wdata[0]),  64'd0);
        chk("rst_hold",  64'(cpu_hold[0]),   64'd0);
        chk("rst_done",  64'(load_done[0]),  64'd0);
        rst = 1'b0;
        step();

        // Two-word stream with byte_valid effectively held high
        load_en[0] = 1'b1;
        step();
        chk("a_ready_collect", 64'(byte_ready[0]), 64'd1);
        chk("a_hold_collect",  64'(cpu_hold[0]),   64'd1);
        for (int i = 0; i < 4; i++) send_byte(0, s1[i], 0);
        chk("a_w0_we",    64'(mem_we[0]),     64'd1);
        chk("a_w0_addr",  64'(addr_a),        64'd0);
        chk("a_w0_data",  64'(mem_wdata[0]),  64'h00100513);
        chk("a_w0_ready", 64'(byte_ready[0]), 64'd0);
        step();
        chk("a_w0_we_off", 64'(mem_we[0]), 64'd0);
        chk("a_addr_inc",  64'(addr_a),    64'd1);
        for (int i = 4; i < 8; i++) send_byte(0, s1[i], 0);
        chk("a_w1_we",   64'(mem_we[0]),    64'd1);
        chk("a_w1_addr", 64'(addr_a),       64'd1);
        chk("a_w1_data", 64'(mem_wdata[0]), 64'h00A585B3);
        step();
        chk("a_w1_we_off", 64'(mem_we[0]), 64'd0);
        chk("a_nwrites2",  64'(q0.size()), 64'd2);
        chk("a_log0", 64'(q0[0]), {25'd0, 7'd0, 32'h00100513});
        chk("a_log1", 64'(q0[1]), {25'd0, 7'd1, 32'h00A585B3});

        // Word at address 2, then abort after two bytes of word 3
        for (int i = 0; i < 4; i++) send_byte(0, 8'hA0 + 8'(i), 0);
        step();
        send_byte(0, 8'hEE, 0);
        send_byte(0, 8'hEE, 0);
        load_en[0] = 1'b0;
        step();
        chk("a_abort_ready", 64'(byte_ready[0]), 64'd0);
        chk("a_abort_hold",  64'(cpu_hold[0]),   64'd0);
        repeat (3) step();
        chk("a_abort_nwr", 64'(q0.size()), 64'd3);
        chk("a_log2", 64'(q0[2]), {25'd0, 7'd2, 32'hA3A2A1A0});
        load_en[0] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_byte(0, 8'h11 * 8'(i + 1), 0);
        chk("a_reload_we",   64'(mem_we[0]),    64'd1);
        chk("a_reload_addr", 64'(addr_a),       64'd0);
        chk("a_reload_data", 64'(mem_wdata[0]), 64'h44332211);
        step();

        // Continue to the word at address 5 and reset during its write cycle
        for (int w = 1; w <= 5; w++) begin
            for (int j = 0; j < 4; j++) send_byte(0, 8'(w * 4 + j), 0);
            if (w < 5) step();
        end
        chk("a_w5_we",   64'(mem_we[0]),    64'd1);
        chk("a_w5_addr", 64'(addr_a),       64'd5);
        chk("a_w5_data", 64'(mem_wdata[0]), 64'h17161514);
        #1 rst = 1'b1;
        #1;
        chk("a_arst_ready", 64'(byte_ready[0]), 64'd0);
        chk("a_arst_we",    64'(mem_we[0]),     64'd0);
        chk("a_arst_addr",  64'(addr_a),        64'd0);
        chk("a_arst_wdata", 64'(mem_wdata[0]),  64'd0);
        chk("a_arst_hold",  64'(cpu_hold[0]),   64'd0);
        chk("a_arst_done",  64'(load_done[0]),  64'd0);
        #1 rst = 1'b0;
        qn = q0.size();
        repeat (3) step();
        chk("a_arst_nowr", 64'(q0.size()), 64'(qn));
        for (int i = 0; i < 4; i++) send_byte(0, 8'hF0 + 8'(i), 0);
        chk("a_post_rst_addr", 64'(addr_a),       64'd0);
        chk("a_post_rst_data", 64'(mem_wdata[0]), 64'hF3F2F1F0);
        step();

        // byte_valid while IDLE is ignored
        load_en[0] = 1'b0;
        repeat (2) step();
        qn = q0.size();
        byte_valid[0] = 1'b1;
        byte_data[0]  = 8'h5A;
        repeat (3) step();
        chk("a_idle_ready", 64'(byte_ready[0]), 64'd0);
        chk("a_idle_we",    64'(mem_we[0]),     64'd0);
        chk("a_idle_nowr",  64'(q0.size()),     64'(qn));
        byte_valid[0] = 1'b0;

        // NUM_WORDS=2 with random valid gaps
        load_en[2] = 1'b1;
        step();
        for (int i = 0; i < 4; i++) send_byte(2, s1[i], int'($urandom_range(0, 3)));
        chk("c_w0_we",   64'(mem_we[2]),    64'd1);
        chk("c_w0_addr", 64'(addr_c),       64'd0);
        chk("c_w0_data", 64'(mem_wdata[2]), 64'h00100513);
        for (int i = 4; i < 8; i++) send_byte(2, s1[i], int'($urandom_range(0, 3)));
        chk("c_w1_we",   64'(mem_we[2]),    64'd1);
        chk("c_w1_addr", 64'(addr_c),       64'd1);
        chk("c_w1_data", 64'(mem_wdata[2]), 64'h00A585B3);
        chk("c_w1_done", 64'(load_done[2]), 64'd0);
        chk("c_w1_hold", 64'(cpu_hold[2]),  64'd1);
        step();
        chk("c_done",      64'(load_done[2]),  64'd1);
        chk("c_done_hold", 64'(cpu_hold[2]),   64'd0);
        chk("c_done_we",   64'(mem_we[2]),     64'd0);
        chk("c_done_addr", 64'(addr_c),        64'd1);
        // byte_valid while DONE is ignored
        byte_valid[2] = 1'b1;
        byte_data[2]  = 8'hC3;
        repeat (3) step();
        chk("c_done_ready", 64'(byte_ready[2]), 64'd0);
        chk("c_done_stay",  64'(load_done[2]),  64'd1);
        chk("c_nwrites",    64'(q2.size()),     64'd2);
        chk("c_log0", 64'(q2[0]), {25'd0, 7'd0, 32'h00100513});
        chk("c_log1", 64'(q2[1]), {25'd0, 7'd1, 32'h00A585B3});
        byte_valid[2] = 1'b0;
        load_en[2] = 1'b0;
        step();
        chk("c_done_clr", 64'(load_done[2]), 64'd0);

        // ADDR_W=2, NUM_WORDS=4: full address space, no fifth write
        load_en[1] = 1'b1;
        step();
        for (int k = 0; k < 16; k++) send_byte(1, 8'h10 + 8'(k), 0);
        chk("b_w3_addr", 64'(addr_b), 64'd3);
        step();
        chk("b_done",      64'(load_done[1]), 64'd1);
        chk("b_done_addr", 64'(addr_b),       64'd3);
        byte_valid[1] = 1'b1;
        repeat (4) step();
        byte_valid[1] = 1'b0;
        chk("b_nwrites", 64'(q1.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("b_log", 64'(q1[i]), {25'd0, 5'd0, 2'(i), wb[i]});
        end
        load_en[1] = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_loader
`default_nettype wire
